mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between the multicycle CPU datapath and the board-level debug read port (the 8-bit debug address pins).
- Sequences every memory access through a fixed issue/wait/respond FSM.
- Returns read data and a one-cycle acknowledge to the winning requester.
- Sits inside the top level, between the CPU datapath, the debug pin logic and the memory.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 32, memory data width.
- MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata (>=1).
- STARVE_MAX, 4, consecutive contested CPU grants before debug is forced to win (>=1).

Ports:
- clk  input  1  system clock (the divided clock in top); all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cpu_req  input  1  CPU access request; held high until cpu_ack.
- cpu_we  input  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_addr  input  ADDR_W  CPU address.
- cpu_wdata  input  DATA_W  CPU write data.
- cpu_ack  output  1  one-cycle completion pulse to the CPU.
- cpu_rdata  output  DATA_W  CPU read data; valid while cpu_ack=1, held afterwards.
- dbg_req  input  1  debug read request; held high until dbg_ack.
- dbg_addr  input  ADDR_W  debug address.
- dbg_ack  output  1  one-cycle completion pulse to the debug port.
- dbg_rdata  output  DATA_W  debug read data; valid while dbg_ack=1, held afterwards.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data.
- arb_state  output  2  current FSM state, for the debug LEDs.
- owner  output  1  0 = CPU, 1 = debug; last granted requester.

Behaviour:
- FSM states (encoding = arb_state):
  - IDLE = 0
  - ISSUE = 1
  - WAIT = 2
  - RESP = 3
- Reset values (any time, including mid-access):
  - FSM returns to IDLE.
  - All outputs 0: acks, mem_en, mem_we, mem_addr, mem_wdata, both rdata registers, owner.
  - Starvation counter cleared.
  - In-flight access is abandoned, with no ack.
- All outputs are registered.
- IDLE:
  - Arbitrates when any req is high.
  - Latches the winner's addr, we and wdata; sets owner; goes to ISSUE.
  - Debug accesses always use we=0.
- Arbitration:
  - Only one requesting: it wins.
  - Both requesting: CPU wins, unless the starvation counter equals STARVE_MAX, in which case debug wins.
- Starvation counter:
  - Increments, saturating at STARVE_MAX, on a CPU grant while dbg_req=1.
  - Clears on any debug grant, and on any grant made while dbg_req=0.
- ISSUE (1 cycle): mem_en=1, with mem_we/mem_addr/mem_wdata from the latch. mem_en is 0 in every other state.
- WAIT: counts MEM_LAT cycles.
  - In the cycle where mem_rdata is valid (MEM_LAT cycles after ISSUE), capture mem_rdata into the owner's rdata register; go to RESP.
  - Writes follow the same timing; the rdata register is not updated on a write.
- RESP (1 cycle): owner's ack=1; then IDLE.
- Latency: request sampled in IDLE at cycle t → ack at cycle t+MEM_LAT+2.
- Minimum period between accesses: MEM_LAT+3 cycles.
- Handshake:
  - Requester deasserts req at the edge where it sees ack.
  - If req is still high in the following IDLE cycle, a new access starts.
  - req, addr and data changes outside IDLE are ignored.
  - req dropped before ack: the access still completes and acks.
- The non-owner's ack stays 0; its rdata register holds its last value.

Decomposition:
- Shared package/include (alongside opcodes.v): state encodings ARB_IDLE/ISSUE/WAIT/RESP and owner codes OWN_CPU/OWN_DBG.
- One natural sub-module, arb_priority: combinational grant plus the starvation counter register.
- Everything else stays in the single module.

Test Plan:
- Reset mid-WAIT (assert at cycle 3 of a CPU read) → arb_state=0, mem_en=0, cpu_ack never pulses, cpu_rdata=0.
- CPU read, addr 0x07, mem returns 0x1234ABCD, MEM_LAT=1; req at t → mem_en=1 at t+1, cpu_ack=1 and cpu_rdata=0x1234ABCD at t+3, arb_state sequence 0,1,2,3,0.
- CPU write, addr 0x10, data 0xDEADBEEF → mem_en=1 and mem_we=1 with that addr/data for exactly one cycle; cpu_ack at t+3; cpu_rdata unchanged.
- Debug read only, dbg_addr=0x07 → owner=1, mem_we=0, dbg_ack with stored word; cpu_ack stays 0.
- Both requesting continuously, STARVE_MAX=4 → grants CPU,CPU,CPU,CPU,DBG,CPU… (repeating); every access is spaced MEM_LAT+3 cycles.
- MEM_LAT=3 rebuild, CPU read → cpu_ack at t+5; back-to-back held req gives the next mem_en exactly 6 cycles after the previous one.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
// Contents:
//   arb_state_e : arbiter FSM states; the encoding is also the arb_state output
//   owner_e     : requester codes for the owner output and the grant decision
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbIssue = 2'd1,
    ArbWait  = 2'd2,
    ArbResp  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OwnCpu = 1'b0,
    OwnDbg = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_arb_priority.sv
// Grant decision between the CPU and the debug read port, plus the starvation counter.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   cpu_req    : CPU request
//   dbg_req    : debug request
//   grant_en   : a grant is taken this cycle (arbiter idle and some request high)
//   grant      : winning requester; only meaningful while a request is high
module arb_priority
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned StarveMax = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   cpu_req,
  input  logic   dbg_req,
  input  logic   grant_en,
  output owner_e grant
);

  localparam int unsigned CntW = $clog2(StarveMax + 1);

  logic [CntW-1:0] starve_q, starve_d;
  logic            starved;

  assign starved = (starve_q == CntW'(StarveMax));

  always_comb begin
    // CPU has priority unless debug has lost StarveMax contested grants in a row.
    grant    = (dbg_req && (!cpu_req || starved)) ? OwnDbg : OwnCpu;
    starve_d = starve_q;
    if (grant_en) begin
      if (grant == OwnCpu && dbg_req) begin
        starve_d = starved ? starve_q : starve_q + CntW'(1);
      end else begin
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the unified memory between the CPU datapath and the debug read port.
// Every access runs IDLE -> ISSUE -> WAIT (MemLat cycles) -> RESP -> IDLE.
// Ports:
//   clk, reset                          : clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata, cpu_ack/rdata : CPU request and completion
//   dbg_req/addr, dbg_ack/rdata          : debug read request and completion
//   mem_en/we/addr/wdata, mem_rdata      : memory interface
//   arb_state                            : current FSM state
//   owner                                : last granted requester (0 CPU, 1 debug)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AddrW     = 8,
  parameter int unsigned DataW     = 32,
  parameter int unsigned MemLat    = 1,
  parameter int unsigned StarveMax = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [AddrW-1:0] cpu_addr,
  input  logic [DataW-1:0] cpu_wdata,
  output logic             cpu_ack,
  output logic [DataW-1:0] cpu_rdata,
  input  logic             dbg_req,
  input  logic [AddrW-1:0] dbg_addr,
  output logic             dbg_ack,
  output logic [DataW-1:0] dbg_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AddrW-1:0] mem_addr,
  output logic [DataW-1:0] mem_wdata,
  input  logic [DataW-1:0] mem_rdata,
  output logic [1:0]       arb_state,
  output logic             owner
);

  localparam int unsigned LatW = $clog2(MemLat + 1);

  arb_state_e       state_q;
  owner_e           owner_q;
  owner_e           grant;
  logic             grant_en;
  logic             acc_we_q;  // write flag of the access in flight; mem_we drops after ISSUE
  logic [LatW-1:0]  lat_cnt_q;
  logic             cpu_ack_q, dbg_ack_q;
  logic [DataW-1:0] cpu_rdata_q, dbg_rdata_q;
  logic             mem_en_q, mem_we_q;
  logic [AddrW-1:0] mem_addr_q;
  logic [DataW-1:0] mem_wdata_q;

  assign grant_en = (state_q == ArbIdle) && (cpu_req || dbg_req);

  arb_priority #(
    .StarveMax (StarveMax)
  ) u_arb_priority (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .dbg_req  (dbg_req),
    .grant_en (grant_en),
    .grant    (grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ArbIdle;
      owner_q     <= OwnCpu;
      acc_we_q    <= 1'b0;
      lat_cnt_q   <= '0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        ArbIdle: begin
          if (grant_en) begin
            // The mem_* registers double as the access latch.
            owner_q  <= grant;
            mem_en_q <= 1'b1;
            if (grant == OwnDbg) begin
              acc_we_q   <= 1'b0;
              mem_we_q   <= 1'b0;
              mem_addr_q <= dbg_addr;
            end else begin
              acc_we_q    <= cpu_we;
              mem_we_q    <= cpu_we;
              mem_addr_q  <= cpu_addr;
              mem_wdata_q <= cpu_wdata;
            end
            state_q <= ArbIssue;
          end
        end
        ArbIssue: begin
          mem_en_q  <= 1'b0;
          mem_we_q  <= 1'b0;
          lat_cnt_q <= LatW'(1);
          state_q   <= ArbWait;
        end
        ArbWait: begin
          if (lat_cnt_q == LatW'(MemLat)) begin
            // mem_rdata is valid in this cycle.
            if (owner_q == OwnDbg) begin
              dbg_ack_q <= 1'b1;
              if (!acc_we_q) dbg_rdata_q <= mem_rdata;
            end else begin
              cpu_ack_q <= 1'b1;
              if (!acc_we_q) cpu_rdata_q <= mem_rdata;
            end
            state_q <= ArbResp;
          end else begin
            lat_cnt_q <= lat_cnt_q + LatW'(1);
          end
        end
        ArbResp: begin
          cpu_ack_q <= 1'b0;
          dbg_ack_q <= 1'b0;
          state_q   <= ArbIdle;
        end
        default: state_q <= ArbIdle;
      endcase
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = dbg_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign arb_state = state_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a MemLat=1 instance carries the directed
// tests, a MemLat=3 instance checks latency scaling.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          dbg;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  // Instance A (MemLat = 1)
  logic        cpu_req, cpu_we, cpu_ack, dbg_req, dbg_ack, mem_en, mem_we, owner;
  logic [7:0]  cpu_addr, dbg_addr, mem_addr;
  logic [31:0] cpu_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic [1:0]  arb_state;

  mem_port_arbiter #(.AddrW(8), .DataW(32), .MemLat(1), .StarveMax(4)) dut_a (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .arb_state(arb_state), .owner(owner)
  );

  // Instance B (MemLat = 3)
  logic        b_cpu_req, b_cpu_we, b_cpu_ack, b_dbg_req, b_dbg_ack, b_mem_en, b_mem_we, b_owner;
  logic [7:0]  b_cpu_addr, b_dbg_addr, b_mem_addr;
  logic [31:0] b_cpu_wdata, b_cpu_rdata, b_dbg_rdata, b_mem_wdata, b_mem_rdata;
  logic [1:0]  b_arb_state;

  mem_port_arbiter #(.AddrW(8), .DataW(32), .MemLat(3), .StarveMax(4)) dut_b (
    .clk(clk), .reset(reset),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
    .dbg_req(b_dbg_req), .dbg_addr(b_dbg_addr), .dbg_ack(b_dbg_ack), .dbg_rdata(b_dbg_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .arb_state(b_arb_state), .owner(b_owner)
  );

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return (a == 8'h07) ? 32'h1234ABCD : {24'h5A5A5A, a};
  endfunction

  // Memory model A: one-cycle read latency, garbage outside the valid cycle.
  bit [31:0]   mem_a [256];
  bit [255:0]  wr_a;
  logic [31:0] rd_a = 32'hEEEE_EEEE;
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem_a[mem_addr] <= mem_wdata;
      wr_a[mem_addr]  <= 1'b1;
    end
    rd_a <= (mem_en && !mem_we) ?
            (wr_a[mem_addr] ? mem_a[mem_addr] : init_word(mem_addr)) : 32'hEEEE_EEEE;
  end
  assign mem_rdata = rd_a;

  // Memory model B: read-only, three-cycle latency.
  logic [31:0] pb0 = 32'hEEEE_EEEE, pb1 = 32'hEEEE_EEEE, pb2 = 32'hEEEE_EEEE;
  always @(posedge clk) begin
    pb0 <= (b_mem_en && !b_mem_we) ? init_word(b_mem_addr) : 32'hEEEE_EEEE;
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign b_mem_rdata = pb2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic score_ack();
    exp_t e;
    chk("sb_pending", 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("ack_pair", {62'd0, cpu_ack, dbg_ack}, e.dbg ? 64'd1 : 64'd2);
      chk("ack_owner", 64'(owner), 64'(e.dbg));
      chk("ack_rdata", e.dbg ? dbg_rdata : cpu_rdata, e.rdata);
    end
  endtask

  // One isolated access on instance A with timing, latch and state-sequence checks.
  task automatic access(input bit dbg, input bit we, input logic [7:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd);
    int start, en_cyc, n_en, ack_cyc, stray;
    logic [9:0] seq;
    @(negedge clk);
    seq = {8'd0, arb_state};
    if (dbg) begin
      dbg_req = 1'b1; dbg_addr = a;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    end
    sb.push_back('{dbg: dbg, rdata: exp_rd});
    start = cyc; en_cyc = -1; n_en = 0; ack_cyc = -1; stray = 0;
    for (int i = 0; i < 12 && ack_cyc < 0; i++) begin
      @(negedge clk);
      seq = {seq[7:0], arb_state};
      if (dbg ? cpu_ack : dbg_ack) stray++;
      if (mem_en) begin
        n_en++;
        if (en_cyc < 0) en_cyc = cyc;
        chk("mem_we", 64'(mem_we), 64'(we && !dbg));
        chk("mem_addr", 64'(mem_addr), 64'(a));
        if (we && !dbg) chk("mem_wdata", 64'(mem_wdata), 64'(d));
      end
      if (cpu_ack || dbg_ack) begin
        ack_cyc = cyc;
        score_ack();
        cpu_req = 1'b0;
        dbg_req = 1'b0;
      end
    end
    @(negedge clk);
    seq = {seq[7:0], arb_state};
    chk("ack_latency", 64'(ack_cyc - start), 64'd3);
    chk("en_latency", 64'(en_cyc - start), 64'd1);
    chk("en_count", 64'(n_en), 64'd1);
    chk("stray_ack", 64'(stray), 64'd0);
    chk("state_seq", 64'(seq), 64'(10'b00_01_10_11_00));
  endtask

  initial begin
    int start, prev_en, grants, acks, n_ack, en1, en2, ack1;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; dbg_req = 0; dbg_addr = 0;
    b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0; b_dbg_req = 0; b_dbg_addr = 0;
    repeat (2) @(negedge clk);
    chk("rst_state", 64'(arb_state), 64'd0);
    chk("rst_acks", {62'd0, cpu_ack, dbg_ack}, 64'd0);
    chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
    chk("rst_rdata", {cpu_rdata, dbg_rdata}, 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    reset = 1'b0;

    // CPU read, CPU write, debug reads.
    access(1'b0, 1'b0, 8'h07, 32'h0, 32'h1234ABCD);
    access(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h1234ABCD);
    access(1'b1, 1'b0, 8'h07, 32'h0, 32'h1234ABCD);
    chk("dbg_cpu_rdata_hold", 64'(cpu_rdata), 64'h1234ABCD);
    access(1'b1, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF);
    access(1'b0, 1'b0, 8'h22, 32'h0, 32'h5A5A5A22);
    chk("cpu_dbg_rdata_hold", 64'(dbg_rdata), 64'hDEADBEEF);

    // Both requesting continuously: every fifth grant goes to debug.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h07; dbg_req = 1'b1; dbg_addr = 8'h10;
    for (int i = 0; i < 12; i++)
      sb.push_back('{dbg: (i % 5 == 4), rdata: (i % 5 == 4) ? 32'hDEADBEEF : 32'h1234ABCD});
    prev_en = -1; grants = 0; acks = 0;
    for (int i = 0; i < 70 && acks < 12; i++) begin
      @(negedge clk);
      if (mem_en) begin
        if (prev_en >= 0) chk("starve_spacing", 64'(cyc - prev_en), 64'd4);
        prev_en = cyc;
        chk("starve_grant", 64'(owner), 64'(grants % 5 == 4));
        grants++;
      end
      if (cpu_ack || dbg_ack) begin
        score_ack();
        acks++;
        if (acks == 12) begin
          cpu_req = 1'b0;
          dbg_req = 1'b0;
        end
      end
    end
    chk("starve_acks", 64'(acks), 64'd12);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    @(negedge clk);

    // Reset in the WAIT state of a CPU read abandons the access.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h07;
    repeat (2) @(negedge clk);
    chk("pre_rst_state", 64'(arb_state), 64'd2);
    reset = 1'b1;
    #1;
    chk("midrst_state", 64'(arb_state), 64'd0);
    chk("midrst_mem_en", 64'(mem_en), 64'd0);
    chk("midrst_cpu_rdata", 64'(cpu_rdata), 64'd0);
    chk("midrst_dbg_rdata", 64'(dbg_rdata), 64'd0);
    @(negedge clk);
    cpu_req = 1'b0;
    reset = 1'b0;
    n_ack = 0;
    repeat (8) begin
      @(negedge clk);
      if (cpu_ack) n_ack++;
    end
    chk("midrst_no_ack", 64'(n_ack), 64'd0);

    // MemLat = 3: ack at t+5, held request re-issues 6 cycles later.
    @(negedge clk);
    b_cpu_req = 1'b1; b_cpu_addr = 8'h07;
    start = cyc; en1 = -1; en2 = -1; ack1 = -1; acks = 0;
    for (int i = 0; i < 30 && acks < 2; i++) begin
      @(negedge clk);
      if (b_mem_en) begin
        if (en1 < 0) en1 = cyc;
        else if (en2 < 0) en2 = cyc;
      end
      if (b_cpu_ack) begin
        acks++;
        if (ack1 < 0) begin
          ack1 = cyc;
          chk("b_rdata", 64'(b_cpu_rdata), 64'h1234ABCD);
        end
        if (acks == 2) b_cpu_req = 1'b0;
      end
    end
    chk("b_ack_latency", 64'(ack1 - start), 64'd5);
    chk("b_en_gap", 64'(en2 - en1), 64'd6);
    chk("b_acks", 64'(acks), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
